game_referee: RTL and testbench
===============================

# game_referee

Drives the game-side inputs of `game_logic`: it generates the red/green light phases, gates `enable`, sets per-level `max_clicks`/`max_steps`, and decides `win`. It sits between the top-level start button and `game_logic`, consuming `position` and `status_code` and producing everything `game_logic` needs apart from `click`.

## Interface
- `GREEN_MIN`, default 40: minimum green-phase length in clocks.
- `GREEN_MASK`, default 8'h3F: mask on the LFSR value added to `GREEN_MIN`.
- `RED_CYCLES`, default 30: red-phase length in clocks.
- `LIVES`, default 3: lives granted at game start (1..3).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a game from IDLE, WON or LOST.
- `position`  in  3  player position from `game_logic`.
- `status_code`  in  4  status from `game_logic`; encoding is in `game_pkg`.
- `red`  out  1  1 during the red phase.
- `win`  out  1  one-cycle pulse when the current level is cleared.
- `enable`  out  1  1 in GREEN and RED; `game_logic` ignores clicks when 0.
- `max_clicks`  out  5  click budget for the current level.
- `max_steps`  out  3  goal position for the current level.
- `level`  out  2  current level, 0..3.
- `lives`  out  2  remaining lives.
- `state`  out  3  FSM state, for display.

## Operation
- States: IDLE, GREEN, RED, CLEAR, WON, LOST.
- Level table: level 0/1/2/3 gives `max_steps` 3/4/5/7 and `max_clicks` 8/10/12/16. Outputs are registered from `level`.
- IDLE → GREEN on `start`. This transition sets level=0, lives=`LIVES`, and loads the timer.
- GREEN:
  - Timer loads `GREEN_MIN + (lfsr & GREEN_MASK)` on entry and counts down.
  - At 0, go to RED; timer loads `RED_CYCLES`.
- RED:
  - `red`=1. At timer 0, go to GREEN and reload the green time.
- Priority in GREEN/RED, checked each cycle: caught, then goal, then timer.
  - Caught (`status_code`==ST_CAUGHT): decrement lives. If lives was 1, go to LOST. Otherwise go to GREEN with a fresh green timer, and assert `rst_game` internally (see Structure).
  - Out of clicks (`status_code`==ST_NO_CLICKS): handled the same as caught.
  - Goal (`position`==`max_steps`, not caught): go to CLEAR.
- CLEAR:
  - One cycle; `win`=1 for that cycle.
  - If level==3, go to WON. Otherwise increment level and go to GREEN.
- WON / LOST: `enable`=0, `red`=0. `start` restarts the game exactly as from IDLE.
- `start` in GREEN/RED/CLEAR is ignored.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'h5A. It advances every cycle, never reaches zero, and is not reset by `start`.

## Timing
- Reset values:
  - state=IDLE, `red`=0, `win`=0, `enable`=0, level=0, lives=`LIVES`.
  - `max_steps`=3, `max_clicks`=8, timer=0, lfsr=8'h5A.
- All outputs are registered. `enable` rises the cycle after `start` is sampled.
- Green phase length is exactly N clocks, with N = loaded value + 1 (the terminal-count cycle is included). The same rule applies to the red phase.
- The `status_code` and `position` reaction is one cycle: the event is sampled at edge k and the state/outputs change at edge k.
- Reset mid-game returns to the reset values on the next edge, regardless of state.
- A caught event and a goal event on the same cycle are treated as caught only.

## Structure
- `game_pkg` holds:
  - the state enum;
  - the status_code constants (ST_IDLE=0, ST_PLAYING=1, ST_CAUGHT=2, ST_NO_CLICKS=3, ST_DONE=4);
  - the level table constants;
  - the LFSR seed and taps.
- Sub-module `phase_timer`: a loadable 8-bit down-counter with a `zero` flag, reused for both phases.
- Referee-requested `game_logic` reset is exposed as an internal `rst_game` pulse. The top level ORs it with `rst`.

## Test plan
- Reset, then idle for 20 clocks → `enable`=0, `red`=0, `max_steps`=3, `max_clicks`=8, lives=3.
- `start` pulse, `GREEN_MASK`=0 → `enable`=1 next cycle; `red` rises after exactly 41 clocks and stays high for 31 clocks.
- During GREEN, drive `position`=3 → one-cycle `win`, then level=1, `max_steps`=4, `max_clicks`=10.
- Drive `status_code`=2 three times → lives 3→2→1, then LOST with `enable`=0. `start` then restores lives=3, level=0.
- Same cycle: `status_code`=2 and `position`==`max_steps` → lives decrements, no `win`.
- Clear levels 0..3 → `win` pulses 4 times, final state WON. Asserting `rst` while in RED → all reset values on the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the red-light/green-light referee.
// Holds the state encoding, status codes, level table and LFSR definition.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GREEN = 3'd1,
        S_RED   = 3'd2,
        S_CLEAR = 3'd3,
        S_WON   = 3'd4,
        S_LOST  = 3'd5
    } state_e;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_PLAYING   = 4'd1;
    localparam logic [3:0] ST_CAUGHT    = 4'd2;
    localparam logic [3:0] ST_NO_CLICKS = 4'd3;
    localparam logic [3:0] ST_DONE      = 4'd4;

    localparam logic [2:0] STEPS_L0 = 3'd3;
    localparam logic [2:0] STEPS_L1 = 3'd4;
    localparam logic [2:0] STEPS_L2 = 3'd5;
    localparam logic [2:0] STEPS_L3 = 3'd7;

    localparam logic [4:0] CLICKS_L0 = 5'd8;
    localparam logic [4:0] CLICKS_L1 = 5'd10;
    localparam logic [4:0] CLICKS_L2 = 5'd12;
    localparam logic [4:0] CLICKS_L3 = 5'd16;

    localparam logic [7:0] LFSR_SEED = 8'h5A;
    // taps 8,6,5,4 map to bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [2:0] steps_for(logic [1:0] lvl);
        logic [2:0] s;
        unique case (lvl)
            2'd0:    s = STEPS_L0;
            2'd1:    s = STEPS_L1;
            2'd2:    s = STEPS_L2;
            default: s = STEPS_L3;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] clicks_for(logic [1:0] lvl);
        logic [4:0] c;
        unique case (lvl)
            2'd0:    c = CLICKS_L0;
            2'd1:    c = CLICKS_L1;
            2'd2:    c = CLICKS_L2;
            default: c = CLICKS_L3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 8-bit down-counter shared by the green and red phases.
// Holds at zero once it gets there; a load always wins.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       zero
);

    logic [7:0] count;

    // load, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/game_referee.sv
// Referee FSM: red/green phases, levels, lives and win detection.
// All outputs are registered from next-state values.
module game_referee
    import game_pkg::*;
#(
    parameter int unsigned GREEN_MIN  = 40,
    parameter logic [7:0]  GREEN_MASK = 8'h3F,
    parameter int unsigned RED_CYCLES = 30,
    parameter int unsigned LIVES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] position,
    input  logic [3:0] status_code,
    output logic       red,
    output logic       win,
    output logic       enable,
    output logic [4:0] max_clicks,
    output logic [2:0] max_steps,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       rst_game
);

    localparam logic [7:0] GMIN   = 8'(GREEN_MIN);
    localparam logic [7:0] RED_LD = 8'(RED_CYCLES);
    localparam logic [1:0] LIVES0 = 2'(LIVES);

    state_e     st_q;
    state_e     st_n;
    logic [1:0] level_n;
    logic [1:0] lives_n;
    logic       rg_n;
    logic [7:0] lfsr;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_zero;
    logic       fail;
    logic [7:0] green_ld;

    assign fail = (status_code == ST_CAUGHT) ||
                  (status_code == ST_NO_CLICKS);
    assign green_ld = GMIN + (lfsr & GREEN_MASK);
    assign state = st_q;

    phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    // free-running pseudo-random source for green lengths
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // next state: caught beats goal beats phase timeout
    always_comb begin
        st_n     = st_q;
        level_n  = level;
        lives_n  = lives;
        rg_n     = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = green_ld;
        unique case (st_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start) begin
                    st_n     = S_GREEN;
                    level_n  = 2'd0;
                    lives_n  = LIVES0;
                    tmr_load = 1'b1;
                end
            end
            S_GREEN, S_RED: begin
                if (fail) begin
                    lives_n = lives - 2'd1;
                    if (lives == 2'd1) begin
                        st_n = S_LOST;
                    end else begin
                        st_n     = S_GREEN;
                        tmr_load = 1'b1;
                        rg_n     = 1'b1;
                    end
                end else if (position == max_steps) begin
                    st_n = S_CLEAR;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (st_q == S_GREEN) begin
                        st_n    = S_RED;
                        tmr_val = RED_LD;
                    end else begin
                        st_n = S_GREEN;
                    end
                end
            end
            S_CLEAR: begin
                if (level == 2'd3) begin
                    st_n = S_WON;
                end else begin
                    st_n     = S_GREEN;
                    level_n  = level + 2'd1;
                    tmr_load = 1'b1;
                end
            end
            default: st_n = S_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= S_IDLE;
            level      <= 2'd0;
            lives      <= LIVES0;
            red        <= 1'b0;
            win        <= 1'b0;
            enable     <= 1'b0;
            max_steps  <= steps_for(2'd0);
            max_clicks <= clicks_for(2'd0);
            rst_game   <= 1'b0;
        end else begin
            st_q       <= st_n;
            level      <= level_n;
            lives      <= lives_n;
            red        <= (st_n == S_RED);
            win        <= (st_n == S_CLEAR);
            enable     <= (st_n == S_GREEN) || (st_n == S_RED);
            max_steps  <= steps_for(level_n);
            max_clicks <= clicks_for(level_n);
            rst_game   <= rg_n;
        end
    end

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: game-level model plus directed scenarios.
// A second instance with the default mask exercises the random green length.
module tb_game_referee;
    import game_pkg::*;

    localparam int G_MIN  = 40;
    localparam int G_MASK = 0;
    localparam int R_CYC  = 30;
    localparam int N_LIV  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] position = 3'd0;
    logic [3:0] status_code = 4'd0;

    logic       red, win, enable, rst_game;
    logic [4:0] max_clicks;
    logic [2:0] max_steps;
    logic [1:0] level, lives;
    logic [2:0] state;

    logic       r_red, r_win, r_enable, r_rst_game;
    logic [4:0] r_max_clicks;
    logic [2:0] r_max_steps;
    logic [1:0] r_level, r_lives;
    logic [2:0] r_state;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    game_referee #(
        .GREEN_MIN  (G_MIN),
        .GREEN_MASK (8'(G_MASK)),
        .RED_CYCLES (R_CYC),
        .LIVES      (N_LIV)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .position (position), .status_code (status_code),
        .red (red), .win (win), .enable (enable),
        .max_clicks (max_clicks), .max_steps (max_steps),
        .level (level), .lives (lives), .state (state),
        .rst_game (rst_game)
    );

    game_referee u_rnd (
        .clk (clk), .rst (rst), .start (start),
        .position (position), .status_code (status_code),
        .red (r_red), .win (r_win), .enable (r_enable),
        .max_clicks (r_max_clicks), .max_steps (r_max_steps),
        .level (r_level), .lives (r_lives), .state (r_state),
        .rst_game (r_rst_game)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int goal_of(int l);
        case (l)
            0: return 3;
            1: return 4;
            2: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic int budget_of(int l);
        case (l)
            0: return 8;
            1: return 10;
            2: return 12;
            default: return 16;
        endcase
    endfunction

    // game model: m_left = clocks still to spend in the current phase
    state_e     m_st = S_IDLE;
    int         m_level = 0;
    int         m_lives = N_LIV;
    int         m_left = 0;
    bit         m_rg = 1'b0;
    logic [7:0] m_lfsr = 8'h5A;
    logic [7:0] start_lfsr = 8'h00;
    bit         got_start = 1'b0;

    always @(posedge clk) begin
        logic [7:0] prev;
        bit caught;
        if (rst) begin
            m_st = S_IDLE; m_level = 0; m_lives = N_LIV;
            m_left = 0; m_rg = 0; m_lfsr = 8'h5A;
        end else begin
            prev = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
            m_rg = 0;
            caught = (status_code == 4'd2) || (status_code == 4'd3);
            case (m_st)
                S_IDLE, S_WON, S_LOST: if (start) begin
                    if (!got_start) begin
                        start_lfsr = prev;
                        got_start = 1;
                    end
                    m_st = S_GREEN; m_level = 0; m_lives = N_LIV;
                    m_left = G_MIN + (prev & G_MASK) + 1;
                end
                S_GREEN, S_RED: begin
                    if (caught) begin
                        m_lives--;
                        if (m_lives == 0) m_st = S_LOST;
                        else begin
                            m_st = S_GREEN; m_rg = 1;
                            m_left = G_MIN + (prev & G_MASK) + 1;
                        end
                    end else if (int'(position) == goal_of(m_level)) begin
                        m_st = S_CLEAR;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_st == S_GREEN) begin
                                m_st = S_RED; m_left = R_CYC + 1;
                            end else begin
                                m_st = S_GREEN;
                                m_left = G_MIN + (prev & G_MASK) + 1;
                            end
                        end
                    end
                end
                S_CLEAR: begin
                    if (m_level == 3) m_st = S_WON;
                    else begin
                        m_level++; m_st = S_GREEN;
                        m_left = G_MIN + (prev & G_MASK) + 1;
                    end
                end
                default: m_st = S_IDLE;
            endcase
        end
    end

    // compare every cycle once reset has been seen
    always @(posedge clk) begin
        logic [18:0] got, exp;
        #1;
        if (armed) begin
            got = {state, red, win, enable, max_steps, max_clicks,
                   level, lives, rst_game};
            exp = {3'(m_st), m_st == S_RED, m_st == S_CLEAR,
                   (m_st == S_GREEN) || (m_st == S_RED),
                   3'(goal_of(m_level)), 5'(budget_of(m_level)),
                   2'(m_level), 2'(m_lives), m_rg};
            chk("cycle_compare", 32'(got), 32'(exp));
        end
    end

    initial begin
        int d_rise, d_hi, d_fall, r_rise, wins;
        int goals [4];
        goals = '{3, 4, 5, 7};
        @(posedge clk); #1 armed = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("idle_enable", 32'(enable), 0);
        chk("idle_red", 32'(red), 0);
        chk("idle_steps", 32'(max_steps), 3);
        chk("idle_clicks", 32'(max_clicks), 8);
        chk("idle_lives", 32'(lives), 3);
        chk("idle_state", 32'(state), 32'(S_IDLE));

        start = 1;
        @(negedge clk);
        start = 0;
        chk("start_enable", 32'(enable), 1);
        d_rise = 0; d_hi = 0; d_fall = 0; r_rise = 0;
        for (int i = 1; i <= 110; i++) begin
            @(posedge clk); #1;
            if (red && d_rise == 0) d_rise = i;
            if (red && d_fall == 0) d_hi++;
            if (!red && d_rise != 0 && d_fall == 0) d_fall = i;
            if (r_red && r_rise == 0) r_rise = i;
        end
        chk("green_len", 32'(d_rise), 41);
        chk("red_len", 32'(d_hi), 31);
        chk("rnd_green_len", 32'(r_rise),
            32'(40 + (start_lfsr & 8'h3F) + 1));

        @(negedge clk) position = 3'd3;
        @(negedge clk) position = 3'd0;
        chk("goal_win", 32'(win), 1);
        chk("goal_state", 32'(state), 32'(S_CLEAR));
        @(negedge clk);
        chk("win_pulse_end", 32'(win), 0);
        chk("lvl1_level", 32'(level), 1);
        chk("lvl1_steps", 32'(max_steps), 4);
        chk("lvl1_clicks", 32'(max_clicks), 10);

        for (int i = 0; i < 3; i++) begin
            status_code = 4'd2;
            @(negedge clk) status_code = 4'd0;
            chk("catch_lives", 32'(lives), 32'(2 - i));
            if (i == 0) chk("catch_rst_game", 32'(rst_game), 1);
        end
        chk("lost_state", 32'(state), 32'(S_LOST));
        chk("lost_enable", 32'(enable), 0);
        start = 1;
        @(negedge clk) start = 0;
        chk("restart_lives", 32'(lives), 3);
        chk("restart_level", 32'(level), 0);
        chk("restart_enable", 32'(enable), 1);

        status_code = 4'd2;
        position = 3'd3;
        @(negedge clk);
        status_code = 4'd0;
        position = 3'd0;
        chk("both_lives", 32'(lives), 2);
        chk("both_win", 32'(win), 0);
        chk("both_state", 32'(state), 32'(S_GREEN));

        wins = 0;
        for (int lv = 0; lv < 4; lv++) begin
            position = 3'(goals[lv]);
            @(negedge clk) position = 3'd0;
            if (win) wins++;
            @(negedge clk);
        end
        chk("win_count", 32'(wins), 4);
        chk("won_state", 32'(state), 32'(S_WON));
        chk("won_enable", 32'(enable), 0);

        start = 1;
        @(negedge clk) start = 0;
        repeat (45) @(negedge clk);
        chk("in_red", 32'(red), 1);
        rst = 1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_red", 32'(red), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_steps", 32'(max_steps), 3);
        chk("rst_clicks", 32'(max_clicks), 8);
        rst = 0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
